// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the output-link arbiter and its round-robin picker.
// ID_W and FLIT_W mirror the node-wide link widths.
package pkt_arb_pkg;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned FLIT_W = 32;

    localparam logic QOS_HI = 1'b1;
    localparam logic QOS_LO = 1'b0;

    typedef struct packed {
        logic              qos;
        logic [1:0]        pkt_type;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   tgt;
        logic [FLIT_W-1:0] data;
    } pkt_t;

    // Index width for an n-entry round-robin, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pkt_link_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping N-1 -> 0.
module rr_pick
    import pkt_arb_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    logic [N-1:0]   rot;
    logic [IDX_W:0] sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        sum   = '0;
        gnt_c = '0;
        any_c = |req;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (rot[k[IDX_W-1:0]]) begin
                sum = {1'b0, ptr} + (IDX_W+1)'(k);
            end
        end
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        idx_c = sum[IDX_W-1:0];
        if (any_c) begin
            gnt_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/pkt_link_arb.sv
// Output-link scheduler: two-class QoS arbitration with per-class round-robin,
// a starvation guard for the low class, and a single registered output stage.
module pkt_link_arb
    import pkt_arb_pkg::*;
#(
    parameter  int unsigned N_REQ      = 8,
    parameter  int unsigned STARVE_LIM = 4,
    localparam int unsigned IDX_W      = idx_w(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_vld,
    output logic [N_REQ-1:0]             req_rdy,
    input  logic [N_REQ-1:0]             req_qos,
    input  logic [N_REQ-1:0][1:0]        req_type,
    input  logic [N_REQ-1:0][ID_W-1:0]   req_src,
    input  logic [N_REQ-1:0][ID_W-1:0]   req_tgt,
    input  logic [N_REQ-1:0][FLIT_W-1:0] req_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic                         out_qos,
    output logic [1:0]                   out_type,
    output logic [ID_W-1:0]              out_src,
    output logic [ID_W-1:0]              out_tgt,
    output logic [FLIT_W-1:0]            out_data,
    output logic [IDX_W-1:0]             out_gnt_id
);

    localparam int unsigned SC_W = idx_w(STARVE_LIM + 1);

    logic [N_REQ-1:0] hi_req_c, lo_req_c, hi_gnt_c, lo_gnt_c, gnt_c;
    logic [IDX_W-1:0] hi_idx_c, lo_idx_c, gnt_idx_c, nxt_ptr_c;
    logic [IDX_W-1:0] hi_ptr, lo_ptr;
    logic             hi_any_c, lo_any_c, starve_hit_c, use_lo_c;
    logic             any_vld_c, load_c, xfer_c;
    logic [SC_W-1:0]  starve_cnt;
    pkt_t             sel_pkt_c, out_pkt;

    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            hi_req_c[i] = req_vld[i] && (req_qos[i] == QOS_HI);
            lo_req_c[i] = req_vld[i] && (req_qos[i] == QOS_LO);
        end
    end

    rr_pick #(.N(N_REQ)) u_pick_hi (
        .req   (hi_req_c),
        .ptr   (hi_ptr),
        .gnt_c (hi_gnt_c),
        .idx_c (hi_idx_c),
        .any_c (hi_any_c)
    );

    rr_pick #(.N(N_REQ)) u_pick_lo (
        .req   (lo_req_c),
        .ptr   (lo_ptr),
        .gnt_c (lo_gnt_c),
        .idx_c (lo_idx_c),
        .any_c (lo_any_c)
    );

    // Class select and grant; ready is held low during reset since load is otherwise true.
    always_comb begin
        starve_hit_c = (STARVE_LIM != 0) && (starve_cnt == SC_W'(STARVE_LIM)) && lo_any_c;
        use_lo_c     = !hi_any_c || starve_hit_c;
        gnt_c        = use_lo_c ? lo_gnt_c : hi_gnt_c;
        gnt_idx_c    = use_lo_c ? lo_idx_c : hi_idx_c;
        any_vld_c    = |req_vld;
        load_c       = !out_vld || out_rdy;
        xfer_c       = load_c && any_vld_c;
        req_rdy      = (xfer_c && rst_n) ? gnt_c : '0;
        nxt_ptr_c    = (gnt_idx_c == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
        sel_pkt_c    = '{qos:      req_qos[gnt_idx_c],
                         pkt_type: req_type[gnt_idx_c],
                         src:      req_src[gnt_idx_c],
                         tgt:      req_tgt[gnt_idx_c],
                         data:     req_data[gnt_idx_c]};
    end

    // Output register, per-class pointers and starvation counter all advance only on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_pkt    <= '0;
            out_gnt_id <= '0;
            hi_ptr     <= '0;
            lo_ptr     <= '0;
            starve_cnt <= '0;
        end else if (load_c) begin
            out_vld <= any_vld_c;
            if (any_vld_c) begin
                out_pkt    <= sel_pkt_c;
                out_gnt_id <= gnt_idx_c;
                if (use_lo_c) begin
                    lo_ptr     <= nxt_ptr_c;
                    starve_cnt <= '0;
                end else begin
                    hi_ptr <= nxt_ptr_c;
                    if (!lo_any_c) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != SC_W'(STARVE_LIM)) begin
                        starve_cnt <= starve_cnt + SC_W'(1);
                    end
                end
            end
        end
    end

    assign out_qos  = out_pkt.qos;
    assign out_type = out_pkt.pkt_type;
    assign out_src  = out_pkt.src;
    assign out_tgt  = out_pkt.tgt;
    assign out_data = out_pkt.data;

endmodule

// File: tb/tb_pkt_link_arb.sv
// Self-checking bench for pkt_link_arb: directed vector table, hand-written corner
// sequences, and a randomized run against a behavioural model plus an order scoreboard.
module tb_pkt_link_arb;
    import pkt_arb_pkg::*;

    localparam int N   = 8;
    localparam int LIM = 4;
    localparam int IW  = 3;

    logic                   clk, rst_n;
    logic [N-1:0]           req_vld, req_rdy, req_qos;
    logic [N-1:0][1:0]      req_type;
    logic [N-1:0][ID_W-1:0] req_src, req_tgt;
    logic [N-1:0][FLIT_W-1:0] req_data;
    logic                   out_vld, out_rdy, out_qos;
    logic [1:0]             out_type;
    logic [ID_W-1:0]        out_src, out_tgt;
    logic [FLIT_W-1:0]      out_data;
    logic [IW-1:0]          out_gnt_id;

    pkt_link_arb #(.N_REQ(N), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_qos(req_qos), .req_type(req_type),
        .req_src(req_src), .req_tgt(req_tgt), .req_data(req_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_qos(out_qos), .out_type(out_type),
        .out_src(out_src), .out_tgt(out_tgt), .out_data(out_data), .out_gnt_id(out_gnt_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: class pointers, starvation count and the output slot.
    int   m_hi_ptr, m_lo_ptr, m_starve, m_id;
    bit   m_vld;
    pkt_t m_pkt;
    logic [ID_W-1:0] sb_q[$];

    typedef struct {
        logic [N-1:0]    vld;
        logic [N-1:0]    qos;
        logic            rdy;
        logic            e_vld;
        logic [IW-1:0]   e_id;
        logic [ID_W-1:0] e_src;
        logic            e_qos;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] vec, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (vec[i[IW-1:0]]) return i;
        end
        return -1;
    endfunction

    // Index the model expects to be granted this cycle, or -1 when nothing transfers.
    function automatic int model_grant(output bit use_lo);
        logic [N-1:0] hi, lo;
        hi     = req_vld & req_qos;
        lo     = req_vld & ~req_qos;
        use_lo = (hi == '0) || (LIM != 0 && m_starve == LIM && lo != '0);
        if (m_vld && !out_rdy) return -1;
        if (req_vld == '0) return -1;
        return use_lo ? pick(lo, m_lo_ptr) : pick(hi, m_hi_ptr);
    endfunction

    task automatic model_reset();
        m_hi_ptr = 0;
        m_lo_ptr = 0;
        m_starve = 0;
        m_id     = 0;
        m_vld    = 1'b0;
        m_pkt    = '0;
        sb_q.delete();
    endtask

    task automatic model_clock();
        int g;
        bit ul;
        bit lo_any;
        logic [IW-1:0] gi;
        g      = model_grant(ul);
        lo_any = (req_vld & ~req_qos) != '0;
        if (m_vld && !out_rdy) return;
        if (g < 0) begin
            m_vld = 1'b0;
            return;
        end
        gi    = g[IW-1:0];
        m_pkt = '{qos: req_qos[gi], pkt_type: req_type[gi], src: req_src[gi],
                  tgt: req_tgt[gi], data: req_data[gi]};
        m_vld = 1'b1;
        m_id  = g;
        if (ul) begin
            m_lo_ptr = (g + 1) % N;
            m_starve = 0;
        end else begin
            m_hi_ptr = (g + 1) % N;
            m_starve = lo_any ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
        end
    endtask

    // One clock: check ready and scoreboard at negedge, advance model, check outputs after edge.
    task automatic cycle();
        int g;
        bit ul;
        logic [N-1:0] er;
        logic [ID_W-1:0] exp_src;
        @(negedge clk);
        g  = model_grant(ul);
        er = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_rdy", 64'(req_rdy), 64'(er));
        if (out_vld && out_rdy) begin
            exp_src = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
            chk("sb_order", 64'(out_src), 64'(exp_src));
        end
        for (int i = 0; i < N; i++) begin
            if (req_vld[i[IW-1:0]] && req_rdy[i[IW-1:0]]) sb_q.push_back(req_src[i[IW-1:0]]);
        end
        @(posedge clk);
        model_clock();
        #1;
        chk("out_vld",    64'(out_vld),    64'(m_vld));
        chk("out_gnt_id", 64'(out_gnt_id), 64'(m_id));
        chk("out_qos",    64'(out_qos),    64'(m_pkt.qos));
        chk("out_type",   64'(out_type),   64'(m_pkt.pkt_type));
        chk("out_src",    64'(out_src),    64'(m_pkt.src));
        chk("out_tgt",    64'(out_tgt),    64'(m_pkt.tgt));
        chk("out_data",   64'(out_data),   64'(m_pkt.data));
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_vld = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic directed_fields();
        for (int i = 0; i < N; i++) begin
            req_type[i[IW-1:0]] = 2'(i);
            req_src[i[IW-1:0]]  = ID_W'(8'h10 + i);
            req_tgt[i[IW-1:0]]  = ID_W'(8'h20 + i);
            req_data[i[IW-1:0]] = FLIT_W'(32'hD000_0000 + i);
        end
    endtask

    initial begin
        logic [N-1:0]    v;
        logic [ID_W-1:0] s_src;
        logic [IW-1:0]   s_id;
        logic [FLIT_W-1:0] s_data;
        int low;

        // Round-robin, QoS priority, idle hold, then starvation guard 0,0,0,0,1 x2.
        tbl[0] = '{8'h29, 8'h00, 1'b1, 1'b1, 3'd0, 8'h10, 1'b0};
        tbl[1] = '{8'h29, 8'h00, 1'b1, 1'b1, 3'd3, 8'h13, 1'b0};
        tbl[2] = '{8'h29, 8'h00, 1'b1, 1'b1, 3'd5, 8'h15, 1'b0};
        tbl[3] = '{8'h29, 8'h00, 1'b1, 1'b1, 3'd0, 8'h10, 1'b0};
        tbl[4] = '{8'h06, 8'h04, 1'b1, 1'b1, 3'd2, 8'h12, 1'b1};
        tbl[5] = '{8'h02, 8'h04, 1'b1, 1'b1, 3'd1, 8'h11, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 8'h11, 1'b0};
        for (int r = 7; r < 17; r++) begin
            bit lo_turn;
            lo_turn = ((r - 7) % 5) == 4;
            tbl[r] = '{8'h03, 8'h01, 1'b1, 1'b1, lo_turn ? 3'd1 : 3'd0,
                       lo_turn ? 8'h11 : 8'h10, !lo_turn};
        end

        rst_n   = 1'b0;
        req_vld = '0;
        req_qos = '0;
        out_rdy = 1'b0;
        directed_fields();
        model_reset();

        // Reset held with random traffic: link idle, no ready, zeroed outputs.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 req_vld = N'($urandom);
            req_qos = N'($urandom);
            out_rdy = 1'($urandom);
            @(negedge clk);
            chk("rst_out_vld", 64'(out_vld), 64'(0));
            chk("rst_req_rdy", 64'(req_rdy), 64'(0));
            chk("rst_gnt_id",  64'(out_gnt_id), 64'(0));
            chk("rst_out_src", 64'(out_src), 64'(0));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        v       = N'($urandom_range(1, 255));
        req_vld = v;
        req_qos = '0;
        out_rdy = 1'b1;
        low = N;
        for (int i = N - 1; i >= 0; i--) if (v[i[IW-1:0]]) low = i;
        cycle();
        chk("first_gnt", 64'(out_gnt_id), 64'(low));

        // Directed table from a fresh reset.
        do_reset();
        for (int r = 0; r < 17; r++) begin
            req_vld = tbl[r].vld;
            req_qos = tbl[r].qos;
            out_rdy = tbl[r].rdy;
            cycle();
            chk($sformatf("tbl%0d_vld", r), 64'(out_vld), 64'(tbl[r].e_vld));
            chk($sformatf("tbl%0d_id", r),  64'(out_gnt_id), 64'(tbl[r].e_id));
            chk($sformatf("tbl%0d_src", r), 64'(out_src), 64'(tbl[r].e_src));
            chk($sformatf("tbl%0d_qos", r), 64'(out_qos), 64'(tbl[r].e_qos));
        end

        // Backpressure: output frozen and no grants for 5 cycles, then back-to-back drain.
        req_vld = 8'hF0;
        req_qos = 8'h00;
        out_rdy = 1'b1;
        cycle();
        s_src  = out_src;
        s_id   = out_gnt_id;
        s_data = out_data;
        out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("bp_vld",  64'(out_vld), 64'(1));
            chk("bp_src",  64'(out_src), 64'(s_src));
            chk("bp_id",   64'(out_gnt_id), 64'(s_id));
            chk("bp_data", 64'(out_data), 64'(s_data));
            chk("bp_rdy",  64'(req_rdy), 64'(0));
        end
        out_rdy = 1'b1;
        for (int c = 0; c < 6; c++) cycle();
        req_vld = '0;
        for (int c = 0; c < 2; c++) cycle();

        // Mid-flight reset discards the held packet and restarts the low pointer at 0.
        req_vld = 8'h08;
        out_rdy = 1'b1;
        cycle();
        req_vld = '0;
        out_rdy = 1'b0;
        cycle();
        chk("mf_pre_vld", 64'(out_vld), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mf_async_vld", 64'(out_vld), 64'(0));
        chk("mf_async_rdy", 64'(req_rdy), 64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_vld = 8'h42;
        req_qos = 8'h00;
        out_rdy = 1'b1;
        cycle();
        chk("mf_ptr_restart", 64'(out_gnt_id), 64'(1));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            req_vld = (c % 3 == 0) ? N'($urandom & $urandom) : N'($urandom);
            req_qos = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_type[i[IW-1:0]] = 2'($urandom);
                req_src[i[IW-1:0]]  = ID_W'($urandom);
                req_tgt[i[IW-1:0]]  = ID_W'($urandom);
                req_data[i[IW-1:0]] = FLIT_W'($urandom);
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_link_arb.md
Name: pkt_link_arb

Overview:
- Output-link scheduler for one directional connection of pkt_con_if (one x_* or y_* lane).
- Shares a single outbound vld/rdy link between N_REQ requesters: local injection plus the node's X/Y input ports.
- Two-class QoS priority, round-robin within each class, and a starvation guard for the low class.
- One registered output stage sustains 1 packet/cycle under continuous ready.

Parameters:
- N_REQ, 8, number of requesters (2..16).
- STARVE_LIM, 4, consecutive high-QoS grants allowed while a low-QoS request waits; 0 disables the guard.
- ID_W, `ID_W, source/target node ID width (from top_define.v).
- FLIT_W, `FLIT_W, data payload width (from top_define.v).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  N_REQ  per-requester valid
- req_rdy  out  N_REQ  per-requester ready (one-hot or zero)
- req_qos  in  N_REQ  per-requester QoS bit (1 = high)
- req_type  in  [1:0] x N_REQ  packet type
- req_src  in  [ID_W-1:0] x N_REQ  source ID
- req_tgt  in  [ID_W-1:0] x N_REQ  target ID
- req_data  in  [FLIT_W-1:0] x N_REQ  payload
- out_vld  out  1  link valid (maps to x_vld[k]/y_vld[k])
- out_rdy  in  1  link ready
- out_qos  out  1  granted packet's QoS bit
- out_type  out  2  granted packet's type
- out_src  out  ID_W  granted packet's source ID
- out_tgt  out  ID_W  granted packet's target ID
- out_data  out  FLIT_W  granted packet's payload
- out_gnt_id  out  $clog2(N_REQ)  index of the requester whose packet is in the output register

Behaviour:
- Reset (async assert, sync deassert is upstream's job):
  - out_vld=0; all out_* fields and out_gnt_id = 0.
  - hi_ptr=lo_ptr=0; starve_cnt=0.
  - req_rdy forced to 0 while rst_n=0.
- Load condition: load = !out_vld | out_rdy. This gives a one-entry output register with bypass of drain.
- Class select:
  - hi_any = |(req_vld & req_qos); lo_any = |(req_vld & ~req_qos).
  - Low class is used if !hi_any.
  - Low class is also used if (STARVE_LIM!=0 & starve_cnt==STARVE_LIM & lo_any).
  - Otherwise high class.
- Pick within the selected class: round-robin starting at that class's pointer, searching upward with wrap N_REQ-1 -> 0.
- Grant: req_rdy[g] = load & any_vld; all other req_rdy bits = 0. Transfer on req_vld[g] & req_rdy[g].
- On transfer at edge T:
  - The output register captures the packet fields and gnt_id; out_vld=1 from T+1 (latency 1 cycle).
  - The used class's pointer becomes (g+1) mod N_REQ. The other class's pointer is unchanged.
- On load with no valid request: out_vld <= 0; the fields hold their previous values.
- While out_vld=1 & out_rdy=0: all out_* stable, req_rdy=0, pointers and starve_cnt frozen.
- starve_cnt, updated only on transfer:
  - High grant while lo_any: +1, saturating at STARVE_LIM.
  - Low grant: cleared to 0.
  - High grant with !lo_any: cleared to 0.
- Simultaneous drain and load: the old packet leaves and the new one enters on the same edge; no bubble.
- Requester handshake: a requester must hold req_vld and its fields stable until it sees rdy. The arbiter does not check this. A request that drops before grant is simply skipped.
- Mid-operation reset: an in-flight out_vld packet is discarded. No partial state survives.

Decomposition:
- Package pkt_arb_pkg holds:
  - typedef pkt_t struct {qos; type[1:0]; src[ID_W]; tgt[ID_W]; data[FLIT_W]}.
  - localparam QOS_HI=1'b1, QOS_LO=1'b0.
  - Helper function for the RR index width.
- Sub-module rr_pick: combinational N-wide round-robin priority picker. Inputs: request vector and start pointer. Outputs: one-hot grant, index, any. Instantiated twice, once for the high class and once for the low class.

Test Plan:
- Reset: hold rst_n=0 with random req_vld → out_vld=0, req_rdy=0, out_gnt_id=0. After release, first grant goes to the lowest valid index ≥0.
- RR fairness: req 0,3,5 valid, qos=0, src=0x10/0x13/0x15, out_rdy=1 → out_src sequence 0x10,0x13,0x15,0x10 on cycles 1..4, one per cycle.
- QoS priority: req1 qos=0, req2 qos=1 both valid → req2 granted first (out_qos=1, out_gnt_id=2), req1 next cycle.
- Backpressure: out_vld=1, out_rdy=0 for 5 cycles → out_* unchanged, req_rdy=0. Raise out_rdy → back-to-back drain, no packet lost or duplicated (scoreboard).
- Starvation: STARVE_LIM=4, req0 qos=1 always valid, req1 qos=0 valid → grants 0,0,0,0,1,0,0,0,0,1.
- Reset mid-flight: drop rst_n with out_vld=1, out_rdy=0 → out_vld=0 immediately (async). Pointers restart at 0 after release.
